// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX among NUM_REQ byte requesters.
// Define UART_ARB_WATCHDOG_EN to enable the WDOG_CYCLES stall watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]   ACK,
  output logic [NUM_REQ-1:0]   CPL,
  output logic                 TX_START,
  output logic [7:0]           TX_DATA,
  input  logic                 TX_BUSY,
  input  logic                 TX_DONE,
  output logic                 ARB_BUSY,
  output logic [ID_W-1:0]      GRANT_ID,
  output logic                 WDOG_ERR
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_WAIT_IDLE = 2'd3;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               arb_busy_q, arb_busy_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] cpl_q, cpl_d;

  logic [ID_W-1:0]    hi_pick, lo_pick, pick;
  logic [7:0]         hi_data, lo_data, pick_data;
  logic               hi_vld, lo_vld, pick_vld;

  // Lowest set bit above LAST wins, otherwise wrap to the lowest set bit.
  always_comb begin
    hi_pick = '0;
    lo_pick = '0;
    hi_data = '0;
    lo_data = '0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (REQ[j] && (j > int'(last_q))) begin
        hi_pick = ID_W'(j);
        hi_data = REQ_DATA[8*j +: 8];
        hi_vld  = 1'b1;
      end
      if (REQ[j]) begin
        lo_pick = ID_W'(j);
        lo_data = REQ_DATA[8*j +: 8];
        lo_vld  = 1'b1;
      end
    end
    pick      = hi_vld ? hi_pick : lo_pick;
    pick_data = hi_vld ? hi_data : lo_data;
    pick_vld  = hi_vld | lo_vld;
  end

`ifdef UART_ARB_WATCHDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    arb_busy_d = arb_busy_q;
    ack_d      = '0;
    cpl_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_id_d = pick;
          tx_data_d  = pick_data;
          ack_d      = ONE << pick;
          tx_start_d = 1'b1;
          arb_busy_d = 1'b1;
          state_d    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (TX_BUSY) begin
          tx_start_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (TX_DONE) begin
          cpl_d   = ONE << grant_id_q;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (!TX_DONE && !TX_BUSY) begin
          last_d     = grant_id_q;
          arb_busy_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_ARB_WATCHDOG_EN
    wdog_err_d = 1'b0;
    if (state_q != S_IDLE && state_d == state_q &&
        wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
      tx_start_d = 1'b0;
      wdog_err_d = 1'b1;
      last_d     = grant_id_q;
      arb_busy_d = 1'b0;
      state_d    = S_IDLE;
    end
    wdog_cnt_d = (state_q == S_IDLE || state_d != state_q) ?
                 '0 : wdog_cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      last_q     <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      arb_busy_q <= 1'b0;
      ack_q      <= '0;
      cpl_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      arb_busy_q <= arb_busy_d;
      ack_q      <= ack_d;
      cpl_q      <= cpl_d;
    end
  end

`ifdef UART_ARB_WATCHDOG_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end
  assign WDOG_ERR = wdog_err_q;
`else
  assign WDOG_ERR = 1'b0 && (WDOG_CYCLES > 0);
`endif

  assign ACK      = ack_q;
  assign CPL      = cpl_q;
  assign TX_START = tx_start_q;
  assign TX_DATA  = tx_data_q;
  assign ARB_BUSY = arb_busy_q;
  assign GRANT_ID = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random stimulus against a transaction-level
// arbiter model plus a scripted UART TX responder.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N-1:0]    REQ = '0;
  logic [8*N-1:0]  REQ_DATA = '0;
  logic [N-1:0]    ACK, CPL;
  logic            TX_START;
  logic [7:0]      TX_DATA;
  logic            TX_BUSY = 1'b0;
  logic            TX_DONE = 1'b0;
  logic            ARB_BUSY, WDOG_ERR;
  logic [IW-1:0]   GRANT_ID;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(IW), .WDOG_CYCLES(1024)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA),
    .ACK(ACK), .CPL(CPL), .TX_START(TX_START), .TX_DATA(TX_DATA),
    .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE), .ARB_BUSY(ARB_BUSY),
    .GRANT_ID(GRANT_ID), .WDOG_ERR(WDOG_ERR)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  bit             rand_mode = 1'b0;
  logic [N-1:0]   dir_req   = '0;
  logic [8*N-1:0] dir_data  = '0;

  // Expected outputs after the next clock edge
  logic [N-1:0]  e_ack, e_cpl;
  logic          e_start, e_busy;
  logic [7:0]    e_data;
  logic [IW-1:0] e_gid;
  int            last_m, g_m;
  bit            own_m, busy_seen_m, done_seen_m;
  logic [7:0]    exp_q[$];
  int            wait_cnt[N];

  // UART responder
  int         u_ph, u_cnt;
  logic [7:0] u_last;
  int         cpl_seen[N];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_ack = '0; e_cpl = '0; e_start = 1'b0; e_busy = 1'b0;
    e_data = '0; e_gid = '0;
    last_m = N - 1; g_m = 0;
    own_m = 1'b0; busy_seen_m = 1'b0; done_seen_m = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  task automatic uart_reset();
    TX_BUSY = 1'b0; TX_DONE = 1'b0; u_ph = 0; u_cnt = 0;
  endtask

  task automatic compare_all();
    chk("ack",      32'(ACK),      32'(e_ack));
    chk("cpl",      32'(CPL),      32'(e_cpl));
    chk("tx_start", 32'(TX_START), 32'(e_start));
    chk("tx_data",  32'(TX_DATA),  32'(e_data));
    chk("arb_busy", 32'(ARB_BUSY), 32'(e_busy));
    chk("grant_id", 32'(GRANT_ID), 32'(e_gid));
    chk("wdog_err", 32'(WDOG_ERR), 32'd0);
    for (int i = 0; i < N; i++) if (CPL[i]) cpl_seen[i]++;
  endtask

  task automatic uart_step();
    case (u_ph)
      0: if (TX_START) begin
        u_last = TX_DATA;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_byte unexpected start actual=%0h required=none", TX_DATA);
        end else begin
          chk("tx_byte", 32'(TX_DATA), 32'(exp_q.pop_front()));
        end
        u_cnt = $urandom_range(0, 2);
        u_ph = 1;
      end
      1: if (u_cnt == 0) begin
        TX_BUSY = 1'b1; u_cnt = $urandom_range(1, 5); u_ph = 2;
      end else u_cnt--;
      2: if (u_cnt == 0) begin
        TX_DONE = 1'b1; TX_BUSY = 1'($urandom_range(0, 1));
        u_cnt = $urandom_range(0, 1); u_ph = 3;
      end else u_cnt--;
      3: if (u_cnt == 0) begin
        TX_DONE = 1'b0; TX_BUSY = 1'($urandom_range(0, 1));
        u_ph = TX_BUSY ? 4 : 0;
      end else u_cnt--;
      default: begin TX_BUSY = 1'b0; u_ph = 0; end
    endcase
  endtask

  task automatic drive_req();
    if (!rand_mode) begin
      REQ = dir_req; REQ_DATA = dir_data;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (REQ[i]) begin
        if (ACK[i]) begin
          REQ[i] = 1'($urandom_range(0, 1));
          REQ_DATA[8*i +: 8] = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          REQ[i] = 1'b0;
          REQ_DATA[8*i +: 8] = 8'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        REQ[i] = 1'b1;
        REQ_DATA[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  // Transaction view: free -> granted -> uart busy seen -> done seen -> free
  task automatic model_next();
    int g;
    e_ack = '0; e_cpl = '0;
    for (int i = 0; i < N; i++) if (!REQ[i]) wait_cnt[i] = 0;
    if (!own_m) begin
      if (|REQ) begin
        g = -1;
        for (int k = 1; k <= N; k++)
          if (g < 0 && REQ[(last_m + k) % N]) g = (last_m + k) % N;
        for (int i = 0; i < N; i++)
          if (REQ[i] && i != g) begin
            wait_cnt[i]++;
            chk("fairness", 32'(wait_cnt[i] <= N - 1), 32'd1);
          end
        wait_cnt[g] = 0;
        g_m = g; own_m = 1'b1; busy_seen_m = 1'b0; done_seen_m = 1'b0;
        e_ack[g] = 1'b1; e_start = 1'b1; e_busy = 1'b1;
        e_gid = IW'(g); e_data = REQ_DATA[8*g +: 8];
        exp_q.push_back(e_data);
      end
    end else if (!busy_seen_m) begin
      if (TX_BUSY) begin busy_seen_m = 1'b1; e_start = 1'b0; end
    end else if (!done_seen_m) begin
      if (TX_DONE) begin done_seen_m = 1'b1; e_cpl[g_m] = 1'b1; end
    end else if (!TX_DONE && !TX_BUSY) begin
      last_m = g_m; own_m = 1'b0; e_busy = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge CLK);
    compare_all();
    uart_step();
    drive_req();
    model_next();
  endtask

  task automatic reset_seq(bit check_now);
    RST = 1'b1;
    REQ = '0; dir_req = '0;
    model_reset();
    uart_reset();
    if (check_now) begin
      #1;
      chk("rst_ack",      32'(ACK),      32'd0);
      chk("rst_cpl",      32'(CPL),      32'd0);
      chk("rst_tx_start", 32'(TX_START), 32'd0);
      chk("rst_tx_data",  32'(TX_DATA),  32'd0);
      chk("rst_arb_busy", 32'(ARB_BUSY), 32'd0);
      chk("rst_grant_id", 32'(GRANT_ID), 32'd0);
      chk("rst_wdog_err", 32'(WDOG_ERR), 32'd0);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    step();
    while ((ARB_BUSY || u_ph != 0) && n < 200) begin
      step(); n++;
    end
    chk(nm, 32'(n < 200), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ord[5];
    int exp_ord[5];
    int ng, idx, c0, n;
    exp_ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) cpl_seen[i] = 0;
    #1;
    reset_seq(1'b1);

    // single byte from requester 0
    dir_data = 32'h0000_00A5; dir_req = 4'b0001;
    c0 = cpl_seen[0];
    step();
    dir_req = 4'b0000;
    step();
    chk("t1_ack",      32'(ACK),      32'h1);
    chk("t1_tx_start", 32'(TX_START), 32'h1);
    chk("t1_tx_data",  32'(TX_DATA),  32'hA5);
    wait_idle("t1_idle_timeout");
    chk("t1_cpl_count", 32'(cpl_seen[0] - c0), 32'd1);
    chk("t1_line_byte", 32'(u_last), 32'hA5);

    // all four held: round-robin order from reset
    reset_seq(1'b0);
    dir_data = 32'h1312_1110; dir_req = 4'b1111;
    ng = 0;
    for (int k = 0; k < 300 && ng < 5; k++) begin
      step();
      if (ACK != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (ACK[i]) idx = i;
        ord[ng] = idx;
        chk("t2_data", 32'(TX_DATA), 32'h10 + 32'(idx));
        ng++;
      end
    end
    chk("t2_grants", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk("t2_order", 32'(ord[i]), 32'(exp_ord[i]));
    dir_req = '0;
    wait_idle("t2_idle_timeout");

    // data change after ACK does not reach TX_DATA
    dir_data = 32'h0000_003C; dir_req = 4'b0001;
    step();
    dir_req = '0;
    step();
    chk("t4_ack", 32'(ACK), 32'h1);
    dir_data = 32'h0000_00FF;
    repeat (3) step();
    chk("t4_tx_data", 32'(TX_DATA), 32'h3C);
    wait_idle("t4_idle_timeout");
    chk("t4_line_byte", 32'(u_last), 32'h3C);

    // reset while waiting for DONE
    dir_data = 32'h0000_0055; dir_req = 4'b0001;
    c0 = cpl_seen[0];
    step();
    dir_req = '0;
    n = 0;
    step();
    while (!(ARB_BUSY && !TX_START && u_ph >= 2) && n < 50) begin
      step(); n++;
    end
    chk("t5_reach_wait_done", 32'(n < 50), 32'd1);
    reset_seq(1'b1);
    dir_data = 32'h7700_0000; dir_req = 4'b1000;
    step();
    dir_req = '0;
    step();
    chk("t5_ack",      32'(ACK),      32'h8);
    chk("t5_grant_id", 32'(GRANT_ID), 32'd3);
    chk("t5_tx_data",  32'(TX_DATA),  32'h77);
    wait_idle("t5_idle_timeout");
    chk("t5_no_cpl0", 32'(cpl_seen[0] - c0), 32'd0);

    // random traffic
    rand_mode = 1'b1;
    REQ = '0;
    repeat (4000) step();
    rand_mode = 1'b0;
    dir_req = '0;
    wait_idle("drain_timeout");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
